// File: rtl/sb_rest_mlane.sv
// sb_rest_mlane: multi-lane sign restoration stage at the tail of the RDOQ
// pipeline. Each beat carries LANES quantized magnitudes plus their original
// signed source coefficients. The source sign is applied, the result is
// clipped to the signed COEFF_WIDTH range and the beat is queued in a
// 2-entry output FIFO with valid/ready flow control. A beat counter tags the
// final beat of each coefficient group (CG) and pulses cg_done after it is
// consumed.
//
// Optional feature: define SB_REST_NZ_CNT_EN to count nonzero coefficients
// per CG and present the total on nz_count with the out_last beat. Without
// it nz_count is tied to 0.
//
// Ports:
//   clk, rst        clock (rising edge), asynchronous active-high reset
//   clear           synchronous flush of FIFO, beat counter and NZ count
//   in_valid/ready  input handshake; in_ready decoded from registered count
//   level           LANES unsigned magnitudes, lane i at [i*W +: W]
//   src_coeff       LANES signed source coefficients, same packing
//   blk_pos         block position of lane 0
//   out_valid/ready output handshake
//   dst_coeff       LANES signed restored coefficients
//   out_pos         blk_pos of the head beat
//   out_last        head beat is the last beat of its CG
//   cg_done         one-cycle pulse after a last beat is consumed
//   nz_count        nonzero count of the CG (head last beat only)
module sb_rest_mlane #(
    parameter int COEFF_WIDTH  = 16,
    parameter int ADDR_WIDTH   = 10,
    parameter int LANES        = 4,
    parameter int BEATS_PER_CG = 4,
    localparam int NZ_WIDTH    = $clog2(LANES*BEATS_PER_CG+1)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         clear,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [LANES*COEFF_WIDTH-1:0] level,
    input  logic [LANES*COEFF_WIDTH-1:0] src_coeff,
    input  logic [ADDR_WIDTH-1:0]        blk_pos,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [LANES*COEFF_WIDTH-1:0] dst_coeff,
    output logic [ADDR_WIDTH-1:0]        out_pos,
    output logic                         out_last,
    output logic                         cg_done,
    output logic [NZ_WIDTH-1:0]          nz_count
);

    localparam int CW = (BEATS_PER_CG > 1) ? $clog2(BEATS_PER_CG) : 1;
    localparam logic [COEFF_WIDTH-1:0] MAXP = {1'b0, {(COEFF_WIDTH-1){1'b1}}};
    localparam logic [COEFF_WIDTH-1:0] MAXN = {1'b1, {(COEFF_WIDTH-1){1'b0}}};
    localparam logic [CW-1:0] LAST_BEAT = CW'(BEATS_PER_CG-1);

    logic [LANES*COEFF_WIDTH-1:0] dst_next;
    logic [LANES*COEFF_WIDTH-1:0] mem_data [2];
    logic [ADDR_WIDTH-1:0]        mem_pos  [2];
    logic                         mem_last [2];
    logic [1:0]                   count;
    logic                         wr_ptr;
    logic                         rd_ptr;
    logic [CW-1:0]                beat_cnt;
    logic                         beat_last;
    logic                         push;
    logic                         pop;

    // Sign restore and clip. A zero magnitude yields zero on either sign.
    always_comb begin
        dst_next = '0;
        for (int unsigned i = 0; i < LANES; i++) begin
            logic [COEFF_WIDTH-1:0] lvl;
            logic [COEFF_WIDTH-1:0] mag;
            lvl = level[i*COEFF_WIDTH +: COEFF_WIDTH];
            if (src_coeff[i*COEFF_WIDTH + COEFF_WIDTH-1]) begin
                mag = (lvl > MAXN) ? MAXN : lvl;
                dst_next[i*COEFF_WIDTH +: COEFF_WIDTH] = '0 - mag;
            end else begin
                mag = (lvl > MAXP) ? MAXP : lvl;
                dst_next[i*COEFF_WIDTH +: COEFF_WIDTH] = mag;
            end
        end
    end

    assign in_ready  = ~rst & (count != 2'd2);
    assign out_valid = (count != 2'd0);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;
    assign beat_last = (beat_cnt == LAST_BEAT);

    assign dst_coeff = mem_data[rd_ptr];
    assign out_pos   = mem_pos[rd_ptr];
    assign out_last  = mem_last[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count    <= '0;
            wr_ptr   <= 1'b0;
            rd_ptr   <= 1'b0;
            beat_cnt <= '0;
            cg_done  <= 1'b0;
            for (int unsigned i = 0; i < 2; i++) begin
                mem_data[i] <= '0;
                mem_pos[i]  <= '0;
                mem_last[i] <= 1'b0;
            end
        end else if (clear) begin
            count    <= '0;
            wr_ptr   <= 1'b0;
            rd_ptr   <= 1'b0;
            beat_cnt <= '0;
            cg_done  <= 1'b0;
        end else begin
            cg_done <= pop & mem_last[rd_ptr];
            if (push) begin
                mem_data[wr_ptr] <= dst_next;
                mem_pos[wr_ptr]  <= blk_pos;
                mem_last[wr_ptr] <= beat_last;
                wr_ptr           <= ~wr_ptr;
                beat_cnt         <= beat_last ? '0 : beat_cnt + CW'(1);
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + {1'b0, push} - {1'b0, pop};
        end
    end

`ifdef SB_REST_NZ_CNT_EN
    logic [NZ_WIDTH-1:0] nz_acc;
    logic [NZ_WIDTH-1:0] beat_nz;
    logic [NZ_WIDTH-1:0] nz_total;
    logic [NZ_WIDTH-1:0] mem_nz [2];

    always_comb begin
        beat_nz = '0;
        for (int unsigned i = 0; i < LANES; i++) begin
            if (dst_next[i*COEFF_WIDTH +: COEFF_WIDTH] != '0) begin
                beat_nz = beat_nz + NZ_WIDTH'(1);
            end
        end
        nz_total = nz_acc + beat_nz;
    end

    // Only the last beat of a CG stores a total; other entries' values are
    // never presented because nz_count is gated by out_last.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            nz_acc    <= '0;
            mem_nz[0] <= '0;
            mem_nz[1] <= '0;
        end else if (clear) begin
            nz_acc <= '0;
        end else if (push) begin
            if (beat_last) begin
                mem_nz[wr_ptr] <= nz_total;
                nz_acc         <= '0;
            end else begin
                nz_acc <= nz_total;
            end
        end
    end

    assign nz_count = (out_valid && mem_last[rd_ptr]) ? mem_nz[rd_ptr] : '0;
`else
    assign nz_count = '0;
`endif

endmodule

// File: tb/tb_sb_rest_mlane.sv
module tb_sb_rest_mlane;

    logic        clk = 1'b0;
    logic        rst;
    logic        clear;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] level;
    logic [63:0] src_coeff;
    logic [9:0]  blk_pos;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] dst_coeff;
    logic [9:0]  out_pos;
    logic        out_last;
    logic        cg_done;
    logic [4:0]  nz_count;

    int total = 0;
    int bad   = 0;

`ifdef SB_REST_NZ_CNT_EN
    localparam bit NZ_EN = 1'b1;
`else
    localparam bit NZ_EN = 1'b0;
`endif

    sb_rest_mlane #(
        .COEFF_WIDTH (16),
        .ADDR_WIDTH  (10),
        .LANES       (4),
        .BEATS_PER_CG(4)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .clear    (clear),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .level    (level),
        .src_coeff(src_coeff),
        .blk_pos  (blk_pos),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .dst_coeff(dst_coeff),
        .out_pos  (out_pos),
        .out_last (out_last),
        .cg_done  (cg_done),
        .nz_count (nz_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] lv;
        logic [63:0] sc;
        logic [63:0] ex;
    } vec_t;

    vec_t vecs [8];

    function automatic logic [63:0] pack4(input logic [15:0] a, input logic [15:0] b,
                                          input logic [15:0] c, input logic [15:0] d);
        return {d, c, b, a};
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drives a beat of four equal magnitudes with positive sources.
    task automatic drive_beat(input logic [15:0] v, input logic [9:0] pos);
        in_valid  = 1'b1;
        level     = pack4(v, v, v, v);
        src_coeff = '0;
        blk_pos   = pos;
    endtask

    initial begin
        rst = 1'b1; clear = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        level = '0; src_coeff = '0; blk_pos = '0;

        // Vectors: lanes listed as lane0..lane3.
        vecs[0] = '{pack4(16'd5, 16'd40000, 16'd32768, 16'd0),
                    pack4(16'hFFFD, 16'd7, 16'hFFFF, 16'hFFF7),
                    pack4(16'hFFFB, 16'h7FFF, 16'h8000, 16'h0000)};
        vecs[1] = '{pack4(16'd0, 16'd0, 16'd32767, 16'd32768),
                    pack4(16'hFFFF, 16'd5, 16'd0, 16'd0),
                    pack4(16'h0000, 16'h0000, 16'h7FFF, 16'h7FFF)};
        vecs[2] = '{pack4(16'd65535, 16'd32769, 16'd32767, 16'd1),
                    pack4(16'hFF9C, 16'hFFFF, 16'hFFFF, 16'h8000),
                    pack4(16'h8000, 16'h8000, 16'h8001, 16'hFFFF)};
        vecs[3] = '{pack4(16'd1, 16'd100, 16'd65535, 16'd12345),
                    pack4(16'd1, 16'd32767, 16'd32767, 16'd0),
                    pack4(16'd1, 16'd100, 16'h7FFF, 16'd12345)};
        vecs[4] = '{pack4(16'd32768, 16'd0, 16'd7, 16'd8),
                    pack4(16'h8000, 16'h8000, 16'd7, 16'hFFF8),
                    pack4(16'h8000, 16'h0000, 16'd7, 16'hFFF8)};
        vecs[5] = '{pack4(16'd2, 16'd3, 16'd4, 16'd5),
                    pack4(16'd0, 16'hFFFF, 16'd0, 16'hFFFF),
                    pack4(16'd2, 16'hFFFD, 16'd4, 16'hFFFB)};
        vecs[6] = '{pack4(16'd32766, 16'd32766, 16'd0, 16'd16384),
                    pack4(16'hFFFB, 16'd5, 16'hFFFB, 16'hFFFB),
                    pack4(16'h8002, 16'h7FFE, 16'h0000, 16'hC000)};
        vecs[7] = '{pack4(16'd1, 16'd1, 16'd1, 16'd1),
                    pack4(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF),
                    pack4(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF)};

        // Reset state.
        #2;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        chk("rst_cg_done", 64'(cg_done), 64'd0);
        chk("rst_nz_count", 64'(nz_count), 64'd0);
        chk("rst_dst", dst_coeff, 64'd0);
        chk("rst_pos_last", {53'd0, out_pos, out_last}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        step();
        chk("post_rst_in_ready", 64'(in_ready), 64'd1);

`ifdef SB_REST_NZ_CNT_EN
        // NZ: CG with 4 nonzero lanes, then an all-zero CG.
        for (int c = 0; c < 2; c++) begin
            for (int k = 0; k < 4; k++) begin
                in_valid = 1'b1; src_coeff = '0; blk_pos = 10'(k);
                level = '0;
                if (c == 0) begin
                    case (k)
                        0: level = pack4(16'd1, 16'd0, 16'd0, 16'd2);
                        2: level = pack4(16'd3, 16'd0, 16'd0, 16'd0);
                        3: level = pack4(16'd0, 16'd0, 16'd0, 16'd4);
                        default: level = '0;
                    endcase
                end
                step();
                chk("nz_cg", 64'(nz_count), (k == 3 && c == 0) ? 64'd4 : 64'd0);
            end
        end
        in_valid = 1'b0;
        step();
`endif

        // Table: one beat each, sign/clip result 1 cycle after accept.
        for (int i = 0; i < 8; i++) begin
            in_valid  = 1'b1;
            level     = vecs[i].lv;
            src_coeff = vecs[i].sc;
            blk_pos   = 10'(i * 10);
            step();
            in_valid = 1'b0;
            chk($sformatf("vec%0d_valid", i), 64'(out_valid), 64'd1);
            chk($sformatf("vec%0d_dst", i), dst_coeff, vecs[i].ex);
            chk($sformatf("vec%0d_pos", i), 64'(out_pos), 64'(i * 10));
            chk($sformatf("vec%0d_last", i), 64'(out_last), 64'((i % 4) == 3));
            step();
            chk($sformatf("vec%0d_drain", i), 64'(out_valid), 64'd0);
            chk($sformatf("vec%0d_cg_done", i), 64'(cg_done), 64'((i % 4) == 3));
        end

        // Streaming: 8 back-to-back beats, out_ready held high.
        out_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            drive_beat(16'(k + 1), 10'(k + 20));
            step();
            chk("stream_in_ready", 64'(in_ready), 64'd1);
            chk("stream_valid", 64'(out_valid), 64'd1);
            chk("stream_pos", 64'(out_pos), 64'(k + 20));
            chk("stream_dst", dst_coeff, pack4(16'(k + 1), 16'(k + 1), 16'(k + 1), 16'(k + 1)));
            chk("stream_last", 64'(out_last), 64'((k % 4) == 3));
            chk("stream_cg_done", 64'(cg_done), 64'((k % 4) == 0 && k > 0));
            chk("stream_nz", 64'(nz_count), (NZ_EN && (k % 4) == 3) ? 64'd16 : 64'd0);
        end
        in_valid = 1'b0;
        step();
        chk("stream_end_valid", 64'(out_valid), 64'd0);
        chk("stream_end_cg_done", 64'(cg_done), 64'd1);

        // Backpressure: 5 stalled cycles, only 2 accepted, head stable.
        out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            drive_beat(16'(100 + (k < 2 ? k : 2)), 10'(100 + (k < 2 ? k : 2)));
            step();
            chk("bp_head_pos", 64'(out_pos), 64'd100);
            chk("bp_head_dst", dst_coeff, pack4(16'd100, 16'd100, 16'd100, 16'd100));
            chk("bp_in_ready", 64'(in_ready), (k == 0) ? 64'd1 : 64'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        chk("bp_drain1_valid", 64'(out_valid), 64'd1);
        chk("bp_drain1_pos", 64'(out_pos), 64'd101);
        chk("bp_drain1_in_ready", 64'(in_ready), 64'd1);
        step();
        chk("bp_drain2_valid", 64'(out_valid), 64'd0);

        // Push and pop together at count=1; beats 2 and 3 of the CG.
        drive_beat(16'd7, 10'd200);
        step();
        chk("pp_first_pos", 64'(out_pos), 64'd200);
        drive_beat(16'd8, 10'd201);
        step();
        chk("pp_valid", 64'(out_valid), 64'd1);
        chk("pp_pos", 64'(out_pos), 64'd201);
        chk("pp_in_ready", 64'(in_ready), 64'd1);
        chk("pp_last", 64'(out_last), 64'd1);
        in_valid = 1'b0;
        step();
        chk("pp_drain_valid", 64'(out_valid), 64'd0);
        chk("pp_cg_done", 64'(cg_done), 64'd1);

        // Clear at count=2 mid-CG.
        out_ready = 1'b0;
        drive_beat(16'd9, 10'd300);
        step();
        drive_beat(16'd9, 10'd301);
        step();
        chk("clr_full_in_ready", 64'(in_ready), 64'd0);
        clear     = 1'b1;
        out_ready = 1'b1;
        step();
        clear    = 1'b0;
        in_valid = 1'b0;
        chk("clr_valid", 64'(out_valid), 64'd0);
        chk("clr_cg_done", 64'(cg_done), 64'd0);
        chk("clr_in_ready", 64'(in_ready), 64'd1);
        for (int k = 0; k < 4; k++) begin
            drive_beat(16'd3, 10'(400 + k));
            step();
            chk("clr_next_last", 64'(out_last), 64'(k == 3));
            chk("clr_next_cg_done", 64'(cg_done), 64'd0);
        end
        in_valid = 1'b0;
        step();
        chk("clr_next_done", 64'(cg_done), 64'd1);

        // Asynchronous reset mid-stream with two buffered beats.
        out_ready = 1'b0;
        drive_beat(16'd11, 10'd500);
        step();
        drive_beat(16'd11, 10'd501);
        step();
        in_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk("amr_valid", 64'(out_valid), 64'd0);
        chk("amr_cg_done", 64'(cg_done), 64'd0);
        chk("amr_nz", 64'(nz_count), 64'd0);
        chk("amr_in_ready", 64'(in_ready), 64'd0);
        @(negedge clk);
        rst       = 1'b0;
        out_ready = 1'b1;
        step();
        chk("amr_post_valid", 64'(out_valid), 64'd0);
        for (int k = 0; k < 4; k++) begin
            drive_beat(16'd12, 10'(600 + k));
            step();
            chk("amr_restart_pos", 64'(out_pos), 64'(600 + k));
            chk("amr_restart_last", 64'(out_last), 64'(k == 3));
        end
        in_valid = 1'b0;
        step();
        chk("amr_restart_done", 64'(cg_done), 64'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Hard time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout: got running want finished");
        $fatal(1);
    end

endmodule

// File: doc/sb_rest_mlane.md
Name: sb_rest_mlane

Overview:
Multi-lane successor to the single-coefficient sign restoration stage at the tail of the RDOQ pipeline. Per beat it takes LANES quantized magnitudes and their original signed source coefficients. It applies each sign, clips every result to the signed COEFF_WIDTH range, and streams the results through a 2-entry output buffer with valid/ready flow control. A beat counter marks coefficient-group (CG) boundaries so downstream entropy-coding prep receives a per-CG last flag and completion pulse.

Parameters:
COEFF_WIDTH, 16, bits per coefficient, for both level and signed source/destination.
ADDR_WIDTH, 10, bits of block position of lane 0 of a beat.
LANES, 4, coefficients processed per beat; legal values 1, 2, 4, 8, 16.
BEATS_PER_CG, 4, beats forming one coefficient group; LANES*BEATS_PER_CG = 16 for HEVC 4x4 CGs.

Ports:
clk  in  1  clock, all logic on rising edge.
rst  in  1  asynchronous, active-high reset.
clear  in  1  synchronous; empties the buffer and zeroes the beat counter.
in_valid  in  1  input beat valid.
in_ready  out  1  block can accept a beat.
level  in  LANES*COEFF_WIDTH  unsigned magnitudes; lane i at [i*COEFF_WIDTH +: COEFF_WIDTH].
src_coeff  in  LANES*COEFF_WIDTH  signed original coefficients, same lane packing.
blk_pos  in  ADDR_WIDTH  position of lane 0; lane i position is blk_pos+i, implied downstream.
out_valid  out  1  output beat valid.
out_ready  in  1  downstream accepts the beat.
dst_coeff  out  LANES*COEFF_WIDTH  signed restored coefficients, same lane packing.
out_pos  out  ADDR_WIDTH  blk_pos of the beat.
out_last  out  1  beat is the final beat of a CG.
cg_done  out  1  one-cycle pulse after the last beat of a CG is consumed.
nz_count  out  $clog2(LANES*BEATS_PER_CG+1)  nonzero coefficients in the CG; see Optional Feature.

Behaviour:
- Reset, asynchronous on rst=1:
  - buffer count, beat counter, out_valid, cg_done and nz_count are 0.
  - dst_coeff, out_pos and out_last are 0; in_ready is 0 while rst is asserted and 1 from the first cycle after release.
  - Reset mid-CG discards all buffered beats and any partial CG.
- Per-lane arithmetic, combinational before the buffer, with MAXP = 2^(W-1)-1 and MAXN = 2^(W-1):
  - src_coeff >= 0: dst = min(level, MAXP).
  - src_coeff < 0: dst = -min(level, MAXN).
  - level 0 gives dst 0 regardless of sign, so no negative zero.
- Accept: in_valid & in_ready. in_ready = (count != 2), decoded from the registered count; never from out_ready combinationally.
- Buffer: 2-entry FIFO. Each entry holds dst_coeff, out_pos and out_last.
  - out_valid = (count != 0).
  - Head entry stays stable while out_valid & !out_ready.
- Latency: a beat accepted at edge N is presented on out_valid after edge N, i.e. 1 cycle, when the buffer was empty or the pop coincides.
- Throughput: with out_ready held at 1, one beat per cycle sustained; count never exceeds 1.
- Push and pop in the same cycle: count unchanged and FIFO order preserved. When count=2 no push is possible; a pop frees one slot for the next cycle.
- Beat counter: advances on each accepted beat. out_last for the beat is (counter == BEATS_PER_CG-1), captured into the entry. The counter wraps to 0 after that beat.
- cg_done: registered; equals 1 in the cycle after out_valid & out_ready & out_last, else 0.
- clear, priority over push and pop in the same cycle:
  - count and beat counter go to 0; any in-flight accept is dropped.
  - No cg_done pulse is generated.

Optional Feature:
Macro SB_REST_NZ_CNT_EN.
- Defined:
  - A running count of lanes with dst != 0 is accumulated over accepted beats.
  - The CG total is stored per entry alongside the out_last beat. nz_count presents it while that entry is at the head (out_valid & out_last); nz_count is 0 otherwise.
  - The accumulator restarts after the last beat and is cleared by clear and rst.
- Undefined: nz_count is tied to 0 and no counter logic exists.

Test Plan:
- Sign and clip, W=16, LANES=4: level {5, 40000, 32768, 0}, src {-3, 7, -1, -9} -> dst {-5, 32767, -32768, 0}, out_valid 1 cycle after accept.
- Streaming: 8 back-to-back beats with out_ready=1 -> in_ready stays 1 and one output per cycle. out_last on beats 4 and 8; cg_done pulses the cycle after each.
- Backpressure: out_ready=0 for 5 cycles while in_valid=1 -> exactly 2 beats accepted and in_ready drops to 0. The head is held stable; releasing out_ready drains in order with no loss or duplication.
- Simultaneous push/pop at count=1 -> count stays 1 and order is preserved; clear at count=2 mid-CG -> out_valid=0 next cycle, the next CG's out_last lands on its 4th beat, and no cg_done pulse occurs.
- Reset mid-stream: rst asserted asynchronously between edges -> out_valid, cg_done and nz_count are 0 immediately. After release the first CG restarts at beat 0.
- With SB_REST_NZ_CNT_EN: CG with levels {1,0,0,2 | 0,0,0,0 | 3,0,0,0 | 0,0,0,4} -> nz_count = 4 on the out_last beat; a zero CG -> 0.
